kmeans_controller: RTL

KMEANS_CONTROLLER -- requirements
Module: kmeans_controller

---
 rtl/kmeans_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/kmeans_controller.sv
// kmeans_controller -- sequences one k-means run: an assignment pass, a
// summation pass, then a per-cluster divide of the x and y sums by the point
// count. Each new centroid is written out, and iterations repeat until no
// centroid moves or MAX_ITER iterations have been done.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   start                       begin a run (sampled only in IDLE)
//   assign_en / assign_done     assignment pass enable / end pulse
//   sum_en / sum_done           summation pass enable / end pulse
//   sum_sel                     cluster whose sum_x/sum_y/count are read
//   sum_x, sum_y, count         sums and point count of the selected cluster
//   div_req/div_a/div_b         divider request, dividend, divisor
//   div_ack/div_res             divider result valid pulse, quotient
//   cent_we/cent_idx/cent_x/y   centroid write strobe, index, value
//   busy, done, iter, converged run status
module kmeans_controller #(
   parameter int NUM_CLUSTERS = 5,
   parameter int MAX_ITER     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        assign_en,
   input  logic        assign_done,
   output logic        sum_en,
   input  logic        sum_done,
   output logic [2:0]  sum_sel,
   input  logic [23:0] sum_x,
   input  logic [23:0] sum_y,
   input  logic [13:0] count,
   output logic        div_req,
   output logic [23:0] div_a,
   output logic [13:0] div_b,
   input  logic        div_ack,
   input  logic [13:0] div_res,
   output logic        cent_we,
   output logic [2:0]  cent_idx,
   output logic [13:0] cent_x,
   output logic [13:0] cent_y,
   output logic        busy,
   output logic        done,
   output logic [4:0]  iter,
   output logic        converged
);

   typedef enum logic [3:0] {
      IDLE, ASSIGN, SUM, DIVX, DIVY, WRITE, NEXT, CHECK, DONE
   } state_t;

   localparam logic [2:0] LAST     = 3'(NUM_CLUSTERS - 1);
   localparam logic [4:0] ITER_MAX = 5'(MAX_ITER);

   state_t      state;
   logic [13:0] cx [NUM_CLUSTERS];
   logic [13:0] cy [NUM_CLUSTERS];
   logic [13:0] qx, qy;
   logic        changed;
   logic [4:0]  iter_nx;

   assign iter_nx = iter + 5'd1;

   // Outputs are registered and set on the edge that enters the state they
   // belong to, so each strobe lines up with its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         assign_en <= 1'b0;
         sum_en    <= 1'b0;
         sum_sel   <= '0;
         div_req   <= 1'b0;
         div_a     <= '0;
         div_b     <= '0;
         cent_we   <= 1'b0;
         cent_idx  <= '0;
         cent_x    <= '0;
         cent_y    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         iter      <= '0;
         converged <= 1'b0;
         changed   <= 1'b0;
         qx        <= '0;
         qy        <= '0;
         for (int i = 0; i < NUM_CLUSTERS; i++) begin
            cx[i] <= '0;
            cy[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= ASSIGN;
               assign_en <= 1'b1;
               busy      <= 1'b1;
               iter      <= '0;
               changed   <= 1'b0;
            end
            ASSIGN: if (assign_done) begin
               state     <= SUM;
               assign_en <= 1'b0;
               sum_en    <= 1'b1;
            end
            SUM: if (sum_done) begin
               state   <= DIVX;
               sum_en  <= 1'b0;
               sum_sel <= '0;
            end
            // div_req low on entry means no request is outstanding yet.
            DIVX: if (!div_req) begin
               if (count == '0) begin
                  state <= NEXT;            // empty cluster keeps its centroid
               end else begin
                  div_req <= 1'b1;
                  div_a   <= sum_x;
                  div_b   <= count;
               end
            end else if (div_ack) begin
               div_req <= 1'b0;
               qx      <= div_res;
               state   <= DIVY;
            end
            // div_b still holds the count captured in DIVX.
            DIVY: if (!div_req) begin
               div_req <= 1'b1;
               div_a   <= sum_y;
            end else if (div_ack) begin
               div_req  <= 1'b0;
               qy       <= div_res;
               cent_we  <= 1'b1;
               cent_idx <= sum_sel;
               cent_x   <= qx;
               cent_y   <= div_res;
               state    <= WRITE;
            end
            WRITE: begin
               cent_we <= 1'b0;
               if (cx[sum_sel] != qx || cy[sum_sel] != qy) changed <= 1'b1;
               cx[sum_sel] <= qx;
               cy[sum_sel] <= qy;
               state       <= NEXT;
            end
            NEXT: if (sum_sel < LAST) begin
               sum_sel <= sum_sel + 3'd1;
               state   <= DIVX;
            end else begin
               state <= CHECK;
            end
            CHECK: begin
               iter <= iter_nx;
               if (!changed || iter_nx == ITER_MAX) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  converged <= !changed;
               end else begin
                  changed   <= 1'b0;
                  assign_en <= 1'b1;
                  state     <= ASSIGN;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
